// File: rtl/probatina_adder_seq.sv
// Run-level sequencer for the pipelined constant adder: latches a run length and constant,
// gates exactly that many beats into the adder and out to the writer, then signals done.
module probatina_adder_seq #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_ADDER_BIT_WIDTH  = 32,
    parameter int C_LENGTH_WIDTH     = 32
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          ap_start,
    output logic                          ap_done,
    output logic                          ap_ready,
    output logic                          ap_idle,
    input  logic [C_LENGTH_WIDTH-1:0]     ctrl_length,
    input  logic [C_ADDER_BIT_WIDTH-1:0]  ctrl_constant,
    output logic [C_ADDER_BIT_WIDTH-1:0]  adder_constant,
    input  logic                          up_tvalid,
    output logic                          up_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] up_tdata,
    output logic                          ad_s_tvalid,
    input  logic                          ad_s_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] ad_s_tdata,
    output logic                          ad_s_tlast,
    input  logic                          ad_m_tvalid,
    output logic                          ad_m_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] ad_m_tdata,
    output logic                          dn_tvalid,
    input  logic                          dn_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] dn_tdata,
    output logic                          dn_tlast
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [C_LENGTH_WIDTH-1:0] LEN_ONE = C_LENGTH_WIDTH'(1);

    state_t                    state;
    state_t                    state_next;
    logic [C_LENGTH_WIDTH-1:0] in_rem;
    logic [C_LENGTH_WIDTH-1:0] out_rem;
    logic                      in_gate;
    logic                      out_open;
    logic                      in_fire;
    logic                      out_fire;
    logic                      in_zero_next;
    logic                      out_zero_next;
    logic                      start_run;

    assign in_gate  = (state == RUN) && (in_rem != '0);
    assign out_open = ((state == RUN) || (state == DRAIN)) && (out_rem != '0);

    assign ad_s_tvalid = up_tvalid & in_gate;
    assign up_tready   = ad_s_tready & in_gate;
    assign ad_s_tdata  = up_tdata;
    assign ad_s_tlast  = (in_rem == LEN_ONE);

    // The adder's own tlast is not used; the writer's last is derived from our own count.
    assign dn_tvalid   = ad_m_tvalid & out_open;
    assign ad_m_tready = dn_tready & out_open;
    assign dn_tdata    = ad_m_tdata;
    assign dn_tlast    = (out_rem == LEN_ONE);

    assign in_fire  = ad_s_tvalid & ad_s_tready;
    assign out_fire = dn_tvalid & dn_tready;

    assign in_zero_next  = (in_rem == '0) || (in_fire && (in_rem == LEN_ONE));
    assign out_zero_next = (out_rem == '0) || (out_fire && (out_rem == LEN_ONE));

    assign start_run = (state == IDLE) && ap_start && (ctrl_length != '0);

    assign ap_idle  = (state == IDLE);
    assign ap_done  = (state == DONE);
    assign ap_ready = (state == DONE);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ap_start) begin
                    state_next = (ctrl_length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Both counters hitting zero on the same edge skips DRAIN entirely.
                if (in_zero_next && out_zero_next) begin
                    state_next = DONE;
                end else if (in_zero_next) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_zero_next) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            in_rem  <= '0;
            out_rem <= '0;
        end else if (start_run) begin
            in_rem  <= ctrl_length;
            out_rem <= ctrl_length;
        end else begin
            if (in_fire) begin
                in_rem <= in_rem - LEN_ONE;
            end
            if (out_fire) begin
                out_rem <= out_rem - LEN_ONE;
            end
        end
    end

    // Loaded only at run start so the adder sees one constant for the whole run.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            adder_constant <= '0;
        end else if (start_run) begin
            adder_constant <= ctrl_constant;
        end
    end

endmodule

// File: tb/tb_probatina_adder_seq.sv
// Scoreboard bench for probatina_adder_seq: a one-stage adder model closes the loop,
// stimulus pushes expected beats into queues and a negedge monitor pops and compares.
module tb_probatina_adder_seq;

    localparam int DW    = 512;
    localparam int CW    = 32;
    localparam int LW    = 32;
    localparam int LANES = DW / 32;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } exp_t;

    logic          clk;
    logic          areset;
    logic          ap_start;
    logic          ap_done;
    logic          ap_ready;
    logic          ap_idle;
    logic [LW-1:0] ctrl_length;
    logic [CW-1:0] ctrl_constant;
    logic [CW-1:0] adder_constant;
    logic          up_tvalid;
    logic          up_tready;
    logic [DW-1:0] up_tdata;
    logic          ad_s_tvalid;
    logic          ad_s_tready;
    logic [DW-1:0] ad_s_tdata;
    logic          ad_s_tlast;
    logic          ad_m_tvalid;
    logic          ad_m_tready;
    logic [DW-1:0] ad_m_tdata;
    logic          dn_tvalid;
    logic          dn_tready;
    logic [DW-1:0] dn_tdata;
    logic          dn_tlast;

    int n_checks = 0;
    int n_fails  = 0;

    exp_t          out_q[$];
    logic          in_q[$];
    logic [DW-1:0] src_q[$];
    int            src_idx = 0;
    logic          up_fire;
    logic          rand_mode = 1'b0;

    int s_beats = 0;
    int dn_beats = 0;
    int s_valid_cycles = 0;
    int done_cnt = 0;
    int idle_run = 0;
    int last_gap = -1;

    probatina_adder_seq #(
        .C_AXIS_TDATA_WIDTH(DW),
        .C_ADDER_BIT_WIDTH (CW),
        .C_LENGTH_WIDTH    (LW)
    ) dut (
        .aclk          (clk),
        .areset        (areset),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_ready      (ap_ready),
        .ap_idle       (ap_idle),
        .ctrl_length   (ctrl_length),
        .ctrl_constant (ctrl_constant),
        .adder_constant(adder_constant),
        .up_tvalid     (up_tvalid),
        .up_tready     (up_tready),
        .up_tdata      (up_tdata),
        .ad_s_tvalid   (ad_s_tvalid),
        .ad_s_tready   (ad_s_tready),
        .ad_s_tdata    (ad_s_tdata),
        .ad_s_tlast    (ad_s_tlast),
        .ad_m_tvalid   (ad_m_tvalid),
        .ad_m_tready   (ad_m_tready),
        .ad_m_tdata    (ad_m_tdata),
        .dn_tvalid     (dn_tvalid),
        .dn_tready     (dn_tready),
        .dn_tdata      (dn_tdata),
        .dn_tlast      (dn_tlast)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mk_beat(input int idx, input logic [31:0] c);
        logic [DW-1:0] b;
        for (int k = 0; k < LANES; k++) begin
            b[k*32 +: 32] = 32'(idx * LANES + k) + c;
        end
        return b;
    endfunction

    function automatic logic [DW-1:0] add_lanes(input logic [DW-1:0] d, input logic [31:0] c);
        logic [DW-1:0] r;
        for (int k = 0; k < LANES; k++) begin
            r[k*32 +: 32] = d[k*32 +: 32] + c;
        end
        return r;
    endfunction

    // One-register adder stand-in with backpressure.
    logic          a_full;
    logic [DW-1:0] a_hold;
    assign ad_s_tready = !a_full || ad_m_tready;
    assign ad_m_tvalid = a_full;
    assign ad_m_tdata  = a_hold;

    always @(posedge clk or posedge areset) begin
        if (areset) begin
            a_full <= 1'b0;
        end else if (ad_s_tvalid && ad_s_tready) begin
            a_full <= 1'b1;
            a_hold <= add_lanes(ad_s_tdata, adder_constant);
        end else if (ad_m_tvalid && ad_m_tready) begin
            a_full <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Upstream source: walks src_q, advancing on each accepted beat.
    initial begin
        up_tvalid = 1'b0;
        up_tdata  = '0;
        forever begin
            @(negedge clk);
            up_fire = up_tvalid && up_tready;
            @(posedge clk);
            #2;
            if (up_fire) src_idx++;
            if (src_idx < src_q.size()) begin
                up_tvalid = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                up_tdata  = src_q[src_idx];
            end else begin
                up_tvalid = 1'b0;
            end
        end
    end

    initial begin
        dn_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            dn_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        logic l;
        if (ad_s_tvalid) s_valid_cycles++;
        if (ad_s_tvalid && ad_s_tready) begin
            s_beats++;
            chkd("ad_s_tdata_pass", ad_s_tdata, up_tdata);
            if (in_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL ad_s_unexpected: got beat %0d, required none", s_beats);
            end else begin
                l = in_q.pop_front();
                chk("ad_s_tlast", 64'(ad_s_tlast), 64'(l));
            end
        end
        if (dn_tvalid && dn_tready) begin
            dn_beats++;
            if (out_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL dn_unexpected: got beat %0d, required none", dn_beats);
            end else begin
                e = out_q.pop_front();
                chkd("dn_tdata", dn_tdata, e.d);
                chk("dn_tlast", 64'(dn_tlast), 64'(e.last));
            end
        end
        if (ap_done || ap_ready) chk("ap_ready_eq_done", 64'(ap_ready), 64'(ap_done));
        if (ap_done) begin
            done_cnt++;
            last_gap = idle_run;
            idle_run = 0;
        end else if (ap_idle) begin
            idle_run++;
        end
    end

    task automatic add_src(input int first, input int n);
        for (int i = 0; i < n; i++) src_q.push_back(mk_beat(first + i, 32'd0));
    endtask

    task automatic add_exp(input int first, input int len, input logic [31:0] c);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.d    = mk_beat(first + i, c);
            e.last = (i == len - 1);
            out_q.push_back(e);
            in_q.push_back(i == len - 1);
        end
    endtask

    task automatic clear_src();
        src_q.delete();
        src_idx = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 ap_start = 1'b1;
        @(posedge clk);
        #1 ap_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt < target) begin
            n_checks++;
            n_fails++;
            $display("FAIL wait_done: got %0d done pulses, required %0d", done_cnt, target);
        end
    endtask

    task automatic wait_s(input int target, input int budget);
        int n;
        n = 0;
        while (s_beats < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (s_beats < target) begin
            n_checks++;
            n_fails++;
            $display("FAIL wait_s: got %0d input beats, required %0d", s_beats, target);
        end
    endtask

    initial begin
        int d0, sb0, db0, sv0;
        areset        = 1'b1;
        ap_start      = 1'b0;
        ctrl_length   = '0;
        ctrl_constant = '0;
        #1;
        chk("rst_idle", 64'(ap_idle), 64'd1);
        chk("rst_done", 64'(ap_done), 64'd0);
        chk("rst_ad_s_tvalid", 64'(ad_s_tvalid), 64'd0);
        chk("rst_ad_m_tready", 64'(ad_m_tready), 64'd0);
        chk("rst_constant", 64'(adder_constant), 64'd0);
        repeat (3) @(posedge clk);
        #3 areset = 1'b0;

        // Length 4, constant 5, sinks always ready, one surplus upstream beat
        d0 = done_cnt; db0 = dn_beats;
        clear_src();
        add_src(0, 5);
        add_exp(0, 4, 32'd5);
        ctrl_length = 4; ctrl_constant = 5;
        pulse_start();
        @(negedge clk);
        chk("t1_not_idle", 64'(ap_idle), 64'd0);
        chk("t1_constant", 64'(adder_constant), 64'd5);
        chk("t1_first_valid", 64'(ad_s_tvalid), 64'd1);
        wait_done(d0 + 1, 200);
        chk("t1_idle_in_done", 64'(ap_idle), 64'd0);
        @(negedge clk);
        #1;
        chk("t1_idle_after", 64'(ap_idle), 64'd1);
        chk("t1_done_one_cycle", 64'(ap_done), 64'd0);
        chk("t1_dn_beats", 64'(dn_beats - db0), 64'd4);
        chk("t1_extra_not_taken", 64'(src_idx), 64'd4);
        chk("t1_extra_valid", 64'(up_tvalid), 64'd1);
        chk("t1_up_tready_closed", 64'(up_tready), 64'd0);
        chk("t1_done_count", 64'(done_cnt - d0), 64'd1);
        chk("t1_queue_empty", 64'(out_q.size()), 64'd0);
        clear_src();

        // Zero-length run
        d0 = done_cnt; sv0 = s_valid_cycles;
        ctrl_length = 0;
        pulse_start();
        @(negedge clk);
        chk("t2_done_next_cycle", 64'(ap_done), 64'd1);
        @(negedge clk);
        chk("t2_done_pulse_end", 64'(ap_done), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("t2_no_ad_s_valid", 64'(s_valid_cycles - sv0), 64'd0);
        chk("t2_done_count", 64'(done_cnt - d0), 64'd1);

        // Length 16, random valid/ready, constant changed mid-run
        d0 = done_cnt; sb0 = s_beats; db0 = dn_beats;
        rand_mode = 1'b1;
        add_src(10, 16);
        add_exp(10, 16, 32'd5);
        ctrl_length = 16; ctrl_constant = 5;
        pulse_start();
        wait_s(sb0 + 6, 400);
        ctrl_constant = 9;
        repeat (3) @(negedge clk);
        #1;
        chk("t3_constant_held", 64'(adder_constant), 64'd5);
        wait_done(d0 + 1, 1000);
        rand_mode = 1'b0;
        chk("t3_s_beats", 64'(s_beats - sb0), 64'd16);
        chk("t3_dn_beats", 64'(dn_beats - db0), 64'd16);
        chk("t3_queue_empty", 64'(out_q.size()), 64'd0);
        chk("t3_constant_still", 64'(adder_constant), 64'd5);
        repeat (2) @(negedge clk);
        clear_src();

        // Reset after 3 of 8 beats, then a fresh length-2 run with constant 9
        sb0 = s_beats;
        add_src(40, 8);
        add_exp(40, 8, 32'd9);
        ctrl_length = 8;
        pulse_start();
        wait_s(sb0 + 3, 200);
        @(posedge clk);
        #3 areset = 1'b1;
        d0 = done_cnt;
        #1;
        chk("t4_rst_idle", 64'(ap_idle), 64'd1);
        chk("t4_rst_up_tready", 64'(up_tready), 64'd0);
        chk("t4_rst_ad_s_tvalid", 64'(ad_s_tvalid), 64'd0);
        chk("t4_rst_dn_tvalid", 64'(dn_tvalid), 64'd0);
        chk("t4_rst_ad_m_tready", 64'(ad_m_tready), 64'd0);
        chk("t4_rst_constant", 64'(adder_constant), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        clear_src();
        out_q.delete();
        in_q.delete();
        areset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
        db0 = dn_beats;
        add_src(60, 2);
        add_exp(60, 2, 32'd9);
        ctrl_length = 2;
        pulse_start();
        wait_done(d0 + 1, 200);
        chk("t4_fresh_dn_beats", 64'(dn_beats - db0), 64'd2);
        chk("t4_fresh_constant", 64'(adder_constant), 64'd9);
        repeat (2) @(negedge clk);
        clear_src();

        // ap_start held high, length 3: back-to-back runs
        d0 = done_cnt; db0 = dn_beats;
        add_src(70, 6);
        add_exp(70, 3, 32'd3);
        add_exp(73, 3, 32'd3);
        ctrl_length = 3; ctrl_constant = 3;
        @(posedge clk);
        #1 ap_start = 1'b1;
        wait_done(d0 + 1, 200);
        chk("t5_run1_beats", 64'(dn_beats - db0), 64'd3);
        wait_done(d0 + 2, 200);
        ap_start = 1'b0;
        chk("t5_idle_gap", 64'(last_gap), 64'd1);
        chk("t5_run2_beats", 64'(dn_beats - db0), 64'd6);
        repeat (5) @(negedge clk);
        #1;
        chk("t5_done_count", 64'(done_cnt - d0), 64'd2);
        chk("t5_final_idle", 64'(ap_idle), 64'd1);
        chk("t5_queue_empty", 64'(out_q.size() + in_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
